req_encoder_8x3: RTL and testbench

- Sequential 8-to-3 request encoder; the inverse of the one-hot 3x8 select decoder used in the processor datapath.
- Latches up to 8 request lines, arbitrates among them, and presents one 3-bit index with a valid/ack handshake.
- Used to funnel interrupt/peripheral requests into a 3-bit code consumed by the control unit.
- Supports fixed-priority or round-robin selection.

---
 rtl/proc_pkg.sv | 19 +
 rtl/prio_sel_8.sv | 30 +++
 rtl/req_encoder_8x3.sv | 74 +++++++
 tb/tb_req_encoder_8x3.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared constants and types for the request encoder slice.
// Index width, FSM states and a one-hot helper.
package proc_pkg;

  localparam int REQ_N     = 8;
  localparam int REQ_IDX_W = 3;

  typedef logic [0:0] enc_state_t;

  localparam enc_state_t ENC_IDLE  = 1'b0;
  localparam enc_state_t ENC_GRANT = 1'b1;

  function automatic logic [REQ_N-1:0] idx2oh(
    input logic [REQ_IDX_W-1:0] i
  );
    return REQ_N'(1) << i;
  endfunction

endpackage

// File: rtl/prio_sel_8.sv
// Combinational 8-way selector: highest-index-first or
// round-robin starting just after `start`.
module prio_sel_8
  import proc_pkg::*;
(
  input  logic [REQ_N-1:0]     vec,
  input  logic [REQ_IDX_W-1:0] start,
  input  logic                 rr,
  output logic [REQ_IDX_W-1:0] idx,
  output logic                 any
);

  always_comb begin
    idx = '0;
    any = |vec;
    if (rr) begin
      // walk backwards so the nearest hit after start wins
      for (int i = REQ_N - 1; i >= 0; i--) begin
        if (vec[start + REQ_IDX_W'(i + 1)])
          idx = start + REQ_IDX_W'(i + 1);
      end
    end else begin
      for (int i = 0; i < REQ_N; i++) begin
        if (vec[i])
          idx = REQ_IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/req_encoder_8x3.sv
// 8-to-3 request encoder: latches requests, arbitrates,
// and hands out one index at a time over valid/ack.
module req_encoder_8x3
  import proc_pkg::*;
#(
  parameter int N_REQ   = REQ_N,
  parameter int IDX_W   = REQ_IDX_W,
  parameter bit RR_MODE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] mask,
  input  logic             ack,
  output logic [IDX_W-1:0] code,
  output logic             valid,
  output logic [N_REQ-1:0] pending,
  output logic             overflow
);

  enc_state_t       state;
  logic [IDX_W-1:0] rr_ptr;
  logic [N_REQ-1:0] clr;
  logic [N_REQ-1:0] elig;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_any;

  assign clr  = (valid && ack) ? idx2oh(code) : '0;
  assign elig = pending & mask;

  prio_sel_8 u_sel (
    .vec   (elig),
    .start (rr_ptr),
    .rr    (RR_MODE),
    .idx   (sel_idx),
    .any   (sel_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pending  <= '0;
      code     <= '0;
      valid    <= 1'b0;
      overflow <= 1'b0;
      state    <= ENC_IDLE;
      rr_ptr   <= IDX_W'(N_REQ - 1);
    end else begin
      // a fresh request beats the clear of the same bit
      pending <= (pending & ~clr) | req;
      if (|(req & pending & ~clr))
        overflow <= 1'b1;
      case (state)
        ENC_IDLE: begin
          if (en && sel_any) begin
            code  <= sel_idx;
            valid <= 1'b1;
            state <= ENC_GRANT;
          end
        end
        ENC_GRANT: begin
          if (ack) begin
            valid <= 1'b0;
            state <= ENC_IDLE;
            if (RR_MODE)
              rr_ptr <= code;
          end
        end
        default: state <= ENC_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_req_encoder_8x3.sv
// Bench for req_encoder_8x3: fixed-priority and round-robin
// instances, grant codes scored through per-instance queues.
module tb_req_encoder_8x3;

  logic       clk = 1'b0;
  logic       rst;
  logic       en0, ack0, en1, ack1;
  logic [7:0] req0, mask0, req1, mask1;
  logic [2:0] code0, code1;
  logic       valid0, valid1, ovf0, ovf1;
  logic [7:0] pend0, pend1;

  int npass = 0;
  int ntot  = 0;
  int q0[$];
  int q1[$];
  logic v0q = 1'b0;
  logic v1q = 1'b0;

  always #5 clk = ~clk;

  req_encoder_8x3 #(.RR_MODE(1'b0)) dut0 (
    .clk(clk), .rst(rst), .en(en0), .req(req0),
    .mask(mask0), .ack(ack0), .code(code0),
    .valid(valid0), .pending(pend0), .overflow(ovf0)
  );

  req_encoder_8x3 #(.RR_MODE(1'b1)) dut1 (
    .clk(clk), .rst(rst), .en(en1), .req(req1),
    .mask(mask1), .ack(ack1), .code(code1),
    .valid(valid1), .pending(pend1), .overflow(ovf1)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h",
                  nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // grant monitors: each new valid pops one expected code
  always @(negedge clk) begin
    if (valid0 && !v0q) begin
      if (q0.size() == 0) begin
        ntot++;
        $display("FAIL fx grant: got code %0d expected none",
                 code0);
      end else chk("fx grant", code0, q0.pop_front());
    end
    if (valid1 && !v1q) begin
      if (q1.size() == 0) begin
        ntot++;
        $display("FAIL rr grant: got code %0d expected none",
                 code1);
      end else chk("rr grant", code1, q1.pop_front());
    end
    v0q = valid0;
    v1q = valid1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    en0 = 1'b0; ack0 = 1'b0; req0 = 8'hFF; mask0 = 8'h00;
    en1 = 1'b0; ack1 = 1'b0; req1 = 8'hFF; mask1 = 8'h00;
    step();
    step();
    chk("rst hold pend", pend0, 8'h00);
    rst = 1'b0; req0 = 8'h00; req1 = 8'h00;
    step();
    chk("rst pend", pend0, 8'h00);
    chk("rst valid", valid0, 1'b0);
    chk("rst code", code0, 3'd0);
    chk("rst ovf", ovf0, 1'b0);
    chk("rst rr valid", valid1, 1'b0);

    // fixed priority: bits 5 and 2
    mask0 = 8'hFF; en0 = 1'b1;
    req0 = 8'h24;
    q0.push_back(5); q0.push_back(2);
    step();
    req0 = 8'h00;
    chk("fx pend", pend0, 8'h24);
    chk("fx valid lat", valid0, 1'b0);
    step();
    chk("fx valid5", valid0, 1'b1);
    chk("fx code5", code0, 3'd5);
    ack0 = 1'b1;
    step();
    ack0 = 1'b0;
    chk("fx gap", valid0, 1'b0);
    chk("fx pend2", pend0, 8'h04);
    step();
    chk("fx valid2", valid0, 1'b1);
    chk("fx code2", code0, 3'd2);
    ack0 = 1'b1;
    step();
    ack0 = 1'b0;
    chk("fx empty", pend0, 8'h00);
    chk("fx ovf", ovf0, 1'b0);

    // masking and enable
    mask0 = 8'h0F; req0 = 8'h80;
    step();
    req0 = 8'h00;
    step();
    step();
    chk("mask valid", valid0, 1'b0);
    chk("mask pend", pend0, 8'h80);
    mask0 = 8'hFF; en0 = 1'b0;
    step();
    step();
    chk("en0 valid", valid0, 1'b0);
    en0 = 1'b1;
    q0.push_back(7);
    step();
    chk("en1 valid", valid0, 1'b1);
    chk("en1 code", code0, 3'd7);
    ack0 = 1'b1;
    step();
    ack0 = 1'b0;
    chk("en pend", pend0, 8'h00);

    // collisions and overflow
    req0 = 8'h10;
    q0.push_back(4);
    step();
    req0 = 8'h00;
    step();
    chk("col code", code0, 3'd4);
    chk("col ovf0", ovf0, 1'b0);
    req0 = 8'h10;
    step();
    req0 = 8'h00;
    chk("col ovf", ovf0, 1'b1);
    step();
    chk("col sticky", ovf0, 1'b1);
    chk("col hold", code0, 3'd4);
    ack0 = 1'b1; req0 = 8'h10;
    q0.push_back(4);
    step();
    ack0 = 1'b0; req0 = 8'h00;
    chk("col ackv", valid0, 1'b0);
    chk("col set win", pend0, 8'h10);
    step();
    chk("col regrant", valid0, 1'b1);
    chk("col code2", code0, 3'd4);
    ack0 = 1'b1;
    step();
    ack0 = 1'b0;
    chk("col pend0", pend0, 8'h00);
    chk("col ovf end", ovf0, 1'b1);

    // round-robin over bits 1, 3, 6
    mask1 = 8'hFF; en1 = 1'b1;
    q1.push_back(1); q1.push_back(3); q1.push_back(6);
    q1.push_back(1); q1.push_back(3);
    req1 = 8'h4A;
    step();
    req1 = 8'h00;
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < 10 && !valid1; c++) step();
      chk("rr wait", valid1, 1'b1);
      ack1 = 1'b1;
      if (k < 4) req1 = 8'h4A;
      else en1 = 1'b0;
      step();
      ack1 = 1'b0; req1 = 8'h00;
    end
    chk("rr ovf", ovf1, 1'b1);

    // reset in the middle of a grant
    req0 = 8'h08;
    q0.push_back(3);
    step();
    req0 = 8'h00;
    step();
    chk("mid code", code0, 3'd3);
    chk("mid valid", valid0, 1'b1);
    rst = 1'b1; ack0 = 1'b1;
    step();
    rst = 1'b0; ack0 = 1'b0;
    chk("mid rvalid", valid0, 1'b0);
    chk("mid rpend", pend0, 8'h00);
    chk("mid rovf", ovf0, 1'b0);
    step();
    step();
    step();
    chk("mid idle", valid0, 1'b0);
    req0 = 8'h01;
    q0.push_back(0);
    step();
    req0 = 8'h00;
    step();
    chk("mid new", valid0, 1'b1);
    chk("mid code0", code0, 3'd0);
    ack0 = 1'b1;
    step();
    ack0 = 1'b0;
    step();
    step();

    chk("q0 drained", q0.size(), 0);
    chk("q1 drained", q1.size(), 0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
